// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin shared front end for a 10-bit signed radix-4 Booth multiplier
// Optional statistics counters (op_count, stall_count) are enabled with BOOTH_ARB_STATS_EN.
module booth_mul_arbiter #(
  parameter int WIDTH = 10,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, win_id, op_id;
  logic              win_found, can_grant, grant;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [WIDTH:0]    b_ext;
  logic [2*WIDTH-1:0] a_ext, pp, product;
  int                idx;

  // First asserted request at or after rr_ptr, wrapping upward.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    can_grant = 1'b0;
    case (state)
      IDLE: begin
        can_grant = 1'b1;
        if (win_found) state_nxt = MUL;
      end
      MUL:  state_nxt = HOLD;
      HOLD: begin
        if (rsp_ready) begin
          can_grant = 1'b1;
          state_nxt = win_found ? MUL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    grant     = can_grant && win_found && rst_n;
    req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;
  end

  assign rsp_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
      rsp_p  <= '0;
      rsp_id <= '0;
    end else begin
      if (grant) begin
        op_a   <= req_a[int'(win_id)*WIDTH +: WIDTH];
        op_b   <= req_b[int'(win_id)*WIDTH +: WIDTH];
        op_id  <= win_id;
        rr_ptr <= (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;
      end
      if (state == MUL) begin
        rsp_p  <= product;
        rsp_id <= op_id;
      end
    end
  end

  // Radix-4 Booth: recode B in overlapping triplets; the top digit covers B = -512.
  always_comb begin
    b_ext   = {op_b, 1'b0};
    a_ext   = {{WIDTH{op_a[WIDTH-1]}}, op_a};
    pp      = '0;
    product = '0;
    for (int i = 0; i < WIDTH/2; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      product = product + (pp << (2*i));
    end
  end

`ifdef BOOTH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (state == HOLD && rsp_ready && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
      if (state == HOLD && !rsp_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [39:0] req_a = '0;
  logic [39:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_p;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef BOOTH_ARB_STATS_EN
  logic [15:0] op_count, stall_count;
`endif

  booth_mul_arbiter #(.WIDTH(10), .NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
`ifdef BOOTH_ARB_STATS_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] mul_ref(input logic [9:0] a, input logic [9:0] b);
    logic signed [19:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Per-requester operation queues: {a, b}
  logic [19:0] opq [4][$];
  logic [19:0] drv_op;
  logic [3:0]  hs_mask = '0;
  int          rsp_cnt [4] = '{default: 0};

  // Requester driver: present the next queued op once the current one is accepted.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (hs_mask[i] || !req_valid[i]) begin
        if (opq[i].size() > 0) begin
          drv_op          = opq[i].pop_front();
          req_valid[i]    = 1'b1;
          req_a[i*10 +: 10] = drv_op[19:10];
          req_b[i*10 +: 10] = drv_op[9:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transaction-level reference: one op in flight, one result presented, round-robin pointer.
  int          m_rr, m_w;
  logic        m_inf, m_hold, m_found, m_hs;
  logic [19:0] m_ip, m_p;
  logic [1:0]  m_iid, m_id;
  logic [3:0]  m_rdy;
  logic [15:0] m_ops, m_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr = 0; m_inf = 0; m_hold = 0; m_p = 0; m_id = 0; m_ip = 0; m_iid = 0;
      m_ops = 0; m_stall = 0; hs_mask = '0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
`ifdef BOOTH_ARB_STATS_EN
      chk("rst_op_count", op_count, 0);
      chk("rst_stall_count", stall_count, 0);
`endif
    end else begin
      m_found = 0;
      m_w = 0;
      for (int k = 0; k < 4; k++)
        if (!m_found && req_valid[(m_rr + k) % 4]) begin
          m_found = 1;
          m_w = (m_rr + k) % 4;
        end
      m_rdy = (!m_inf && (!m_hold || rsp_ready) && m_found) ? (4'b0001 << m_w) : 4'b0000;
      chk("model_req_ready", req_ready, m_rdy);
      chk("model_rsp_valid", rsp_valid, m_hold);
      chk("model_busy", busy, m_inf || m_hold);
      if (m_hold) begin
        chk("model_rsp_p", rsp_p, m_p);
        chk("model_rsp_id", rsp_id, m_id);
      end
`ifdef BOOTH_ARB_STATS_EN
      chk("model_op_count", op_count, m_ops);
      chk("model_stall_count", stall_count, m_stall);
`endif
      hs_mask = req_valid & req_ready;
      if (rsp_valid && rsp_ready) rsp_cnt[rsp_id]++;
      m_hs = m_hold && rsp_ready;
      if (m_hold && !rsp_ready && m_stall != 16'hFFFF) m_stall++;
      if (m_hs && m_ops != 16'hFFFF) m_ops++;
      if (m_inf) begin
        m_p = m_ip; m_id = m_iid; m_hold = 1;
      end else if (m_hs) begin
        m_hold = 0;
      end
      if (m_rdy != 0) begin
        m_inf = 1;
        m_ip  = mul_ref(req_a[m_w*10 +: 10], req_b[m_w*10 +: 10]);
        m_iid = 2'(m_w);
        m_rr  = (m_w + 1) % 4;
      end else begin
        m_inf = 0;
      end
    end
  end

  task automatic wait_rsp(output logic [19:0] p, output logic [1:0] id);
    bit ok = 0;
    p = '0; id = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid) begin p = rsp_p; id = rsp_id; ok = 1; end
    end
    chk("wait_rsp_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (!busy && req_valid == 0 && opq[0].size() + opq[1].size() + opq[2].size() + opq[3].size() == 0)
        ok = 1;
    end
    chk("wait_idle_timeout", ok, 1);
  endtask

  task automatic single_op(input int id, input logic [9:0] a, input logic [9:0] b,
                           input logic [19:0] exp, input string nm);
    logic [19:0] p;
    logic [1:0]  rid;
    @(posedge clk); #1;
    opq[id].push_back({a, b});
    wait_rsp(p, rid);
    chk({nm, "_p"}, p, exp);
    chk({nm, "_id"}, rid, id);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [19:0] p0, p;
    logic [1:0]  id0, rid;
    int          grants[$], ids[$], times[$];
    int          gi, n, cyc, base[4], issued[4];
    bit          ok;
    logic [9:0]  ra, rb;

    rst_n = 0;
    rsp_ready = 1;
    opq[2].push_back({10'h3FD, 10'd7});          // -3 * 7
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_forces_ready_low", req_ready, 0);
    @(posedge clk); #1 rst_n = 1;

    @(negedge clk); chk("single_grant", req_ready, 4'b0100);
    @(negedge clk); chk("single_mul_ready", req_ready, 0); chk("single_mul_valid", rsp_valid, 0);
    @(negedge clk); chk("single_valid", rsp_valid, 1);
    chk("single_p", rsp_p, 20'hFFFEB); chk("single_id", rsp_id, 2);

    single_op(0, 10'h200, 10'h200, 20'h40000, "neg512_sq");
    single_op(1, 10'h1FF, 10'h200, 20'hC0200, "max_x_neg512");
    single_op(2, 10'h000, 10'h200, 20'h00000, "zero_x_neg512");
    single_op(3, 10'h200, 10'h1FF, 20'hC0200, "neg512_x_max");
    wait_idle();

    // Round-robin: all four valid, requester 0 has a second op
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) opq[i].push_back({10'(i * 37 - 100), 10'(5 - 3 * i)});
    opq[0].push_back({10'd9, 10'h3F6});
    for (int c = 0; c < 40 && ids.size() < 5; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        gi = 0;
        for (int j = 0; j < 4; j++) if (req_ready[j]) gi = j;
        grants.push_back(gi);
      end
      if (rsp_valid && rsp_ready) begin ids.push_back(rsp_id); times.push_back(c); end
    end
    chk("rr_resp_count", ids.size(), 5);
    if (grants.size() == 5 && ids.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_grant_%0d", k), grants[k], k % 4);
        chk($sformatf("rr_id_%0d", k), ids[k], k % 4);
        if (k > 0) chk($sformatf("rr_spacing_%0d", k), times[k] - times[k-1], 2);
      end
    end
    wait_idle();

    // Response backpressure for 5 HOLD cycles
    @(posedge clk); #1;
    rsp_ready = 0;
    opq[1].push_back({10'h3B3, 10'd13});         // -77 * 13
    opq[2].push_back({10'd5, 10'h3FB});
    wait_rsp(p0, id0);
    chk("bp_first_p", p0, 20'hFFC17);
    chk("bp_first_id", id0, 1);
    chk("bp_no_grant_0", req_ready, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_p_stable_%0d", k), rsp_p, p0);
      chk($sformatf("bp_id_stable_%0d", k), rsp_id, id0);
      chk($sformatf("bp_no_grant_%0d", k), req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
`ifdef BOOTH_ARB_STATS_EN
    @(negedge clk);
    chk("bp_stall_count", stall_count, 5);
`endif
    wait_idle();

    // Reset during MUL
    @(posedge clk); #1;
    opq[2].push_back({10'd100, 10'h39C});
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (busy && !rsp_valid) ok = 1;
    end
    chk("mid_reset_reached_mul", ok, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_reset_ready", req_ready, 0);
    chk("mid_reset_valid", rsp_valid, 0);
    chk("mid_reset_p", rsp_p, 0);
    chk("mid_reset_id", rsp_id, 0);
    chk("mid_reset_busy", busy, 0);
    @(posedge clk); #1;
    opq[0].push_back({10'd3, 10'd3});
    opq[3].push_back({10'd4, 10'd4});
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk); chk("post_reset_first_grant", req_ready, 4'b0001);
    wait_rsp(p, rid);
    chk("post_reset_rsp_p", p, 20'd9);
    chk("post_reset_rsp_id", rid, 0);
    wait_idle();

    // Random regression
    for (int i = 0; i < 4; i++) begin base[i] = rsp_cnt[i]; issued[i] = 0; end
    n = 0; cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      rsp_ready = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 4; i++) begin
        if (n < 10000 && opq[i].size() < 2 && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 7))
            0: ra = 10'h200; 1: ra = 10'h1FF; 2: ra = 10'h000; 3: ra = 10'h3FF;
            default: ra = 10'($urandom);
          endcase
          case ($urandom_range(0, 7))
            0: rb = 10'h200; 1: rb = 10'h1FF; 2: rb = 10'h000; 3: rb = 10'h3FF;
            default: rb = 10'($urandom);
          endcase
          opq[i].push_back({ra, rb});
          issued[i]++;
          n++;
        end
      end
    end
    chk("rand_issued_all", n, 10000);
    rsp_ready = 1;
    wait_idle();
    for (int i = 0; i < 4; i++)
      chk($sformatf("rand_resp_count_%0d", i), rsp_cnt[i] - base[i], issued[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
